text_console: RTL

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/text_console.sv
// ---------------------------------------------------------------------------
// text_console
//   Character-stream terminal front end. Accepts one character per valid/ready
//   handshake, keeps a cursor, and issues VRAM writes (glyph index at
//   {row[4:0], col[6:0]}) for printable characters, backspace erasure and
//   blank-line clearing when the cursor moves onto a new row.
//
//   Optional feature macro: TEXT_CONSOLE_CLEAR_EN
//     defined   -> 0x0C (form feed) blanks the whole screen and homes cursor
//     undefined -> 0x0C is an ignored control code
//
// Ports
//   clk_i         : pixel-domain clock, rising edge
//   reset_i       : asynchronous reset, active low
//   char_i        : character / control code
//   char_valid_i  : char_i valid
//   char_ready_o  : block can accept (high only while idle)
//   vram_addr_o   : VRAM write address {row, col}
//   vram_data_o   : VRAM write data
//   vram_we_o     : VRAM write enable, one write per high cycle
//   cursor_col_o  : current cursor column
//   cursor_row_o  : current cursor row
// ---------------------------------------------------------------------------
module text_console #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic [11:0] vram_addr_o,
    output logic [7:0]  vram_data_o,
    output logic        vram_we_o,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o
);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] COLS_L   = 8'(COLS);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

`ifdef TEXT_CONSOLE_CLEAR_EN
    localparam logic [7:0] CH_FF    = 8'h0C;
    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLR_LINE} state_t;
`endif

    state_t      r_state;
    logic        r_ready;
    logic [6:0]  r_col;
    logic [4:0]  r_row;
    logic [7:0]  r_clr_col;   // next column to blank; reaching COLS means done
    logic [11:0] r_addr;
    logic [7:0]  r_data;
    logic        r_we;
`ifdef TEXT_CONSOLE_CLEAR_EN
    logic [4:0]  r_clr_row;
`endif

    logic        w_accept;
    logic        w_printable;
    logic [4:0]  w_next_row;

    assign w_accept    = char_valid_i && r_ready;
    assign w_printable = (char_i >= CH_SPACE);
    assign w_next_row  = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

    assign char_ready_o = r_ready;
    assign vram_addr_o  = r_addr;
    assign vram_data_o  = r_data;
    assign vram_we_o    = r_we;
    assign cursor_col_o = r_col;
    assign cursor_row_o = r_row;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_col     <= 7'd0;
            r_row     <= 5'd0;
            r_clr_col <= 8'd0;
            r_addr    <= 12'd0;
            r_data    <= 8'd0;
            r_we      <= 1'b0;
`ifdef TEXT_CONSOLE_CLEAR_EN
            r_clr_row <= 5'd0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_printable) begin
                            r_addr <= {r_row, r_col};
                            r_data <= char_i;
                            r_we   <= 1'b1;
                            if (r_col == LAST_COL) begin
                                // Line wrap: the new row is blanked after the char write.
                                r_col     <= 7'd0;
                                r_row     <= w_next_row;
                                r_clr_col <= 8'd0;
                                r_state   <= CLR_LINE;
                                r_ready   <= 1'b0;
                            end else begin
                                r_col <= r_col + 7'd1;
                            end
                        end else begin
                            case (char_i)
                                CH_LF: begin
                                    // Column 0 of the new row is blanked right away,
                                    // so the line clear finishes one cycle earlier.
                                    r_col     <= 7'd0;
                                    r_row     <= w_next_row;
                                    r_addr    <= {w_next_row, 7'd0};
                                    r_data    <= CH_SPACE;
                                    r_we      <= 1'b1;
                                    r_clr_col <= 8'd1;
                                    r_state   <= CLR_LINE;
                                    r_ready   <= 1'b0;
                                end
                                CH_CR: r_col <= 7'd0;
                                CH_BS: begin
                                    if (r_col != 7'd0) begin
                                        r_col  <= r_col - 7'd1;
                                        r_addr <= {r_row, r_col - 7'd1};
                                        r_data <= CH_SPACE;
                                        r_we   <= 1'b1;
                                    end
                                end
`ifdef TEXT_CONSOLE_CLEAR_EN
                                CH_FF: begin
                                    r_col     <= 7'd0;
                                    r_row     <= 5'd0;
                                    r_addr    <= 12'd0;
                                    r_data    <= CH_SPACE;
                                    r_we      <= 1'b1;
                                    r_clr_row <= 5'd0;
                                    r_clr_col <= 8'd1;
                                    r_state   <= CLR_SCREEN;
                                    r_ready   <= 1'b0;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_LINE: begin
                    if (r_clr_col == COLS_L) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_addr    <= {r_row, r_clr_col[6:0]};
                        r_data    <= CH_SPACE;
                        r_we      <= 1'b1;
                        r_clr_col <= r_clr_col + 8'd1;
                    end
                end
`ifdef TEXT_CONSOLE_CLEAR_EN
                CLR_SCREEN: begin
                    if (r_clr_col == COLS_L) begin
                        if (r_clr_row == LAST_ROW) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            // Start the next row without a gap cycle.
                            r_addr    <= {r_clr_row + 5'd1, 7'd0};
                            r_data    <= CH_SPACE;
                            r_we      <= 1'b1;
                            r_clr_row <= r_clr_row + 5'd1;
                            r_clr_col <= 8'd1;
                        end
                    end else begin
                        r_addr    <= {r_clr_row, r_clr_col[6:0]};
                        r_data    <= CH_SPACE;
                        r_we      <= 1'b1;
                        r_clr_col <= r_clr_col + 8'd1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
